// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared constants and types for the frame-buffer port arbiter.
//   DEF_ADDR_W / DEF_DATA_W / DEF_NUM_WR / DEF_STARVE_LIMIT : parameter defaults
//   fb_src_t : source of the winner registered onto the RAM port
package fb_arb_pkg;

    localparam int unsigned DEF_ADDR_W       = 16;
    localparam int unsigned DEF_DATA_W       = 8;
    localparam int unsigned DEF_NUM_WR       = 2;
    localparam int unsigned DEF_STARVE_LIMIT = 64;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_DISP,
        SRC_WR
    } fb_src_t;

endpackage

// File: rtl/fb_rr_picker.sv
// fb_rr_picker: combinational round-robin one-hot picker.
//   Req      in  NUM_WR  request vector
//   Rr_Ptr   in  IDX_W   index of the last granted requester
//   Pick     out NUM_WR  one-hot pick (all zero when no request)
//   Pick_Idx out IDX_W   index of the picked requester
// Search starts at Rr_Ptr+1 and wraps modulo NUM_WR.
module fb_rr_picker #(
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned IDX_W  = 1
) (
    input  logic [NUM_WR-1:0] Req,
    input  logic [IDX_W-1:0]  Rr_Ptr,
    output logic [NUM_WR-1:0] Pick,
    output logic [IDX_W-1:0]  Pick_Idx
);

    logic found;

    // Outer loop walks priority offsets 1..NUM_WR, inner loop finds the
    // requester at that offset, keeping every bit-select index constant.
    always_comb begin
        Pick     = '0;
        Pick_Idx = '0;
        found    = 1'b0;
        for (int unsigned k = 1; k <= NUM_WR; k++) begin
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                if (!found && Req[i] && ((32'(Rr_Ptr) + k) % NUM_WR) == i) begin
                    found    = 1'b1;
                    Pick[i]  = 1'b1;
                    Pick_Idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port synchronous frame-buffer RAM between
// the VGA display fetch (strict priority) and NUM_WR round-robin pixel writers.
//   Clk, Reset                     clock, synchronous active-high reset
//   Disp_Req/Disp_Addr/Disp_Ack    display fetch request handshake (Ack combinational)
//   Disp_Valid/Disp_Data           fetched word, two cycles after Disp_Ack
//   Wr_Req/Wr_Addr/Wr_Data/Wr_Gnt  writer request handshake (Gnt combinational one-hot)
//   Mem_Addr/Mem_WrData/Mem_We     registered RAM port
//   Mem_RdData                     RAM read data, one cycle after Mem_Addr
//   Starve_Evt                     pulse on an anti-starvation override grant
// Optional feature: define FB_ARB_STARVE_GUARD_EN to build per-writer wait
// counters that let a writer waiting STARVE_LIMIT cycles override the display.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned NUM_WR       = DEF_NUM_WR,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Disp_Req,
    input  logic [ADDR_W-1:0]            Disp_Addr,
    output logic                         Disp_Ack,
    output logic                         Disp_Valid,
    output logic [DATA_W-1:0]            Disp_Data,
    input  logic [NUM_WR-1:0]            Wr_Req,
    input  logic [NUM_WR-1:0][ADDR_W-1:0] Wr_Addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0] Wr_Data,
    output logic [NUM_WR-1:0]            Wr_Gnt,
    output logic [ADDR_W-1:0]            Mem_Addr,
    output logic [DATA_W-1:0]            Mem_WrData,
    output logic                         Mem_We,
    input  logic [DATA_W-1:0]            Mem_RdData,
    output logic                         Starve_Evt
);

    localparam int unsigned IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    logic [IDX_W-1:0]  rr_ptr;
    logic [NUM_WR-1:0] rr_pick;
    logic [IDX_W-1:0]  rr_idx;

    logic              ovr_hit;
    logic [IDX_W-1:0]  ovr_idx;

    fb_src_t           win_src;
    logic [IDX_W-1:0]  win_idx;
    fb_src_t           mem_src;

    fb_rr_picker #(
        .NUM_WR (NUM_WR),
        .IDX_W  (IDX_W)
    ) u_picker (
        .Req      (Wr_Req),
        .Rr_Ptr   (rr_ptr),
        .Pick     (rr_pick),
        .Pick_Idx (rr_idx)
    );

`ifdef FB_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [NUM_WR-1:0][CNT_W-1:0] wait_cnt;

    // Lowest-index writer that has waited the full limit takes the override.
    always_comb begin
        ovr_hit = 1'b0;
        ovr_idx = '0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (!ovr_hit && Wr_Req[i] && wait_cnt[i] == CNT_W'(STARVE_LIMIT)) begin
                ovr_hit = 1'b1;
                ovr_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                if (!Wr_Req[i] || Wr_Gnt[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign Starve_Evt = ovr_hit & ~Reset;
`else
    assign ovr_hit    = 1'b0;
    assign ovr_idx    = '0;
    assign Starve_Evt = 1'b0;
`endif

    // Requests seen while Reset is high are never acknowledged or granted.
    always_comb begin
        Disp_Ack = 1'b0;
        Wr_Gnt   = '0;
        win_src  = SRC_NONE;
        win_idx  = '0;
        if (!Reset) begin
            if (ovr_hit) begin
                Wr_Gnt  = NUM_WR'(1) << ovr_idx;
                win_src = SRC_WR;
                win_idx = ovr_idx;
            end else if (Disp_Req) begin
                Disp_Ack = 1'b1;
                win_src  = SRC_DISP;
            end else if (|rr_pick) begin
                Wr_Gnt  = rr_pick;
                win_src = SRC_WR;
                win_idx = rr_idx;
            end
        end
    end

    // mem_src is the first stage of the read-valid shift, Disp_Valid the second.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Mem_Addr   <= '0;
            Mem_WrData <= '0;
            mem_src    <= SRC_NONE;
            Disp_Valid <= 1'b0;
            rr_ptr     <= IDX_W'(NUM_WR - 1);
        end else begin
            mem_src    <= win_src;
            Disp_Valid <= (mem_src == SRC_DISP);
            case (win_src)
                SRC_DISP: Mem_Addr <= Disp_Addr;
                SRC_WR: begin
                    Mem_Addr   <= Wr_Addr[win_idx];
                    Mem_WrData <= Wr_Data[win_idx];
                    rr_ptr     <= win_idx;
                end
                default: ;
            endcase
        end
    end

    assign Mem_We    = (mem_src == SRC_WR);
    assign Disp_Data = Mem_RdData;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: scoreboard bench for fb_port_arbiter (NUM_WR=2,
// STARVE_LIMIT=4). Expected RAM-port operations and display read words are
// queued when stimulus is driven and checked when the DUT produces them.
// Build with FB_ARB_STARVE_GUARD_EN defined to exercise the override path.
module tb_fb_port_arbiter;

    logic             Clk;
    logic             Reset;
    logic             Disp_Req;
    logic [15:0]      Disp_Addr;
    logic             Disp_Ack;
    logic             Disp_Valid;
    logic [7:0]       Disp_Data;
    logic [1:0]       Wr_Req;
    logic [1:0][15:0] Wr_Addr;
    logic [1:0][7:0]  Wr_Data;
    logic [1:0]       Wr_Gnt;
    logic [15:0]      Mem_Addr;
    logic [7:0]       Mem_WrData;
    logic             Mem_We;
    logic [7:0]       Mem_RdData;
    logic             Starve_Evt;

    fb_port_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (8),
        .NUM_WR       (2),
        .STARVE_LIMIT (4)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Disp_Req   (Disp_Req),
        .Disp_Addr  (Disp_Addr),
        .Disp_Ack   (Disp_Ack),
        .Disp_Valid (Disp_Valid),
        .Disp_Data  (Disp_Data),
        .Wr_Req     (Wr_Req),
        .Wr_Addr    (Wr_Addr),
        .Wr_Data    (Wr_Data),
        .Wr_Gnt     (Wr_Gnt),
        .Mem_Addr   (Mem_Addr),
        .Mem_WrData (Mem_WrData),
        .Mem_We     (Mem_We),
        .Mem_RdData (Mem_RdData),
        .Starve_Evt (Starve_Evt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Synchronous single-port RAM model with a known initial pattern.
    logic [7:0] ram [0:65535];
    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction
    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = init_val(16'(a));
        ram[16'h0010] = 8'hA5;
    end
    always @(posedge Clk) begin
        if (Mem_We) ram[Mem_Addr] <= Mem_WrData;
        Mem_RdData <= ram[Mem_Addr];
    end

    // Bench-side view of memory contents in grant order.
    logic [7:0] exp_wr [logic [15:0]];
    function automatic logic [7:0] exp_val(input logic [15:0] a);
        if (exp_wr.exists(a)) return exp_wr[a];
        if (a == 16'h0010) return 8'hA5;
        return init_val(a);
    endfunction

    typedef struct {
        int unsigned due;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } op_t;
    typedef struct {
        int unsigned due;
        logic [7:0]  data;
    } rd_t;
    op_t op_q[$];
    rd_t rd_q[$];

    task automatic expect_disp(input logic with_data);
        op_q.push_back('{due: cyc + 1, we: 1'b0, addr: Disp_Addr, data: 8'h00});
        if (with_data) rd_q.push_back('{due: cyc + 2, data: exp_val(Disp_Addr)});
    endtask

    task automatic expect_wr(input logic w);
        op_q.push_back('{due: cyc + 1, we: 1'b1, addr: Wr_Addr[w], data: Wr_Data[w]});
        exp_wr[Wr_Addr[w]] = Wr_Data[w];
    endtask

    task automatic cyc_check(input logic ack, input logic [1:0] gnt, input logic starve);
        check("disp_ack", 32'(Disp_Ack), 32'(ack));
        check("wr_gnt", 32'(Wr_Gnt), 32'(gnt));
        check("starve_evt", 32'(Starve_Evt), 32'(starve));
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard side: RAM port one cycle after grant, read data two after ack.
    always @(negedge Clk) begin
        if (op_q.size() != 0 && op_q[0].due == cyc) begin
            op_t op;
            op = op_q.pop_front();
            check("mem_we", 32'(Mem_We), 32'(op.we));
            check("mem_addr", 32'(Mem_Addr), 32'(op.addr));
            if (op.we) check("mem_wrdata", 32'(Mem_WrData), 32'(op.data));
        end else if (Mem_We === 1'b1) begin
            check("mem_we_unexpected", 32'(Mem_We), 32'd0);
        end
        if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
            rd_t rd;
            rd = rd_q.pop_front();
            check("disp_valid", 32'(Disp_Valid), 32'd1);
            check("disp_data", 32'(Disp_Data), 32'(rd.data));
        end else if (Disp_Valid === 1'b1) begin
            check("disp_valid_unexpected", 32'(Disp_Valid), 32'd0);
        end
    end

    initial begin
        int unsigned acked;
        logic        wr_pend;

        Reset     = 1'b1;
        Disp_Req  = 1'b0;
        Disp_Addr = '0;
        Wr_Req    = '0;
        Wr_Addr   = '0;
        Wr_Data   = '0;
        repeat (3) tick();

        // Idle right after reset: every output at its reset value.
        Reset = 1'b0;
        #2;
        cyc_check(1'b0, 2'b00, 1'b0);
        check("rst_disp_valid", 32'(Disp_Valid), 32'd0);
        check("rst_mem_we", 32'(Mem_We), 32'd0);
        check("rst_mem_addr", 32'(Mem_Addr), 32'd0);
        check("rst_mem_wrdata", 32'(Mem_WrData), 32'd0);

        // Both writers request: writer 0 first, then writer 1.
        tick();
        Wr_Req     = 2'b11;
        Wr_Addr[0] = 16'h0100; Wr_Data[0] = 8'h11;
        Wr_Addr[1] = 16'h0101; Wr_Data[1] = 8'h22;
        #2; cyc_check(1'b0, 2'b01, 1'b0); expect_wr(1'b0);
        tick();
        Wr_Req = 2'b10;
        #2; cyc_check(1'b0, 2'b10, 1'b0); expect_wr(1'b1);
        tick();
        Wr_Req = 2'b00;

        // Single display fetch of 0x0010 (word 0xA5).
        Disp_Req  = 1'b1;
        Disp_Addr = 16'h0010;
        #2; cyc_check(1'b1, 2'b00, 1'b0); expect_disp(1'b1);
        tick();
        Disp_Req = 1'b0;
        #2; cyc_check(1'b0, 2'b00, 1'b0);
        repeat (2) tick();

        // Six cycles of contention between writers: strict alternation 0,1,...
        Wr_Req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            Wr_Addr[0] = 16'(16'h0200 + i); Wr_Data[0] = 8'(8'h60 + i);
            Wr_Addr[1] = 16'(16'h0300 + i); Wr_Data[1] = 8'(8'h80 + i);
            #2;
            if (i % 2 == 0) begin
                cyc_check(1'b0, 2'b01, 1'b0); expect_wr(1'b0);
            end else begin
                cyc_check(1'b0, 2'b10, 1'b0); expect_wr(1'b1);
            end
            tick();
        end
        Wr_Req = 2'b00;

        // Display beats a simultaneous writer; write follows when display drops,
        // then a read of the just-written address returns the new word.
        Disp_Req   = 1'b1;
        Disp_Addr  = 16'h0011;
        Wr_Req     = 2'b01;
        Wr_Addr[0] = 16'h0020; Wr_Data[0] = 8'h3C;
        #2; cyc_check(1'b1, 2'b00, 1'b0); expect_disp(1'b1);
        tick();
        Disp_Req = 1'b0;
        #2; cyc_check(1'b0, 2'b01, 1'b0); expect_wr(1'b0);
        tick();
        Wr_Req    = 2'b00;
        Disp_Req  = 1'b1;
        Disp_Addr = 16'h0020;
        #2; cyc_check(1'b1, 2'b00, 1'b0); expect_disp(1'b1);
        tick();
        Disp_Req = 1'b0;
        repeat (2) tick();

        // Display held continuously while writer 1 waits.
        acked      = 0;
        wr_pend    = 1'b1;
        Wr_Req     = 2'b10;
        Wr_Addr[1] = 16'h0040; Wr_Data[1] = 8'h77;
        Disp_Req   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Disp_Addr = 16'(16'h0030 + acked);
            Wr_Req    = {wr_pend, 1'b0};
            #2;
`ifdef FB_ARB_STARVE_GUARD_EN
            if (i == 4) begin
                cyc_check(1'b0, 2'b10, 1'b1); expect_wr(1'b1);
                wr_pend = 1'b0;
            end else begin
                cyc_check(1'b1, 2'b00, 1'b0); expect_disp(1'b1);
                acked++;
            end
`else
            cyc_check(1'b1, 2'b00, 1'b0); expect_disp(1'b1);
            acked++;
`endif
            tick();
        end
        Disp_Req = 1'b0;
        Wr_Req   = {wr_pend, 1'b0};
        #2;
        if (wr_pend) begin
            cyc_check(1'b0, 2'b10, 1'b0); expect_wr(1'b1);
        end else begin
            cyc_check(1'b0, 2'b00, 1'b0);
        end
        tick();
        Wr_Req = 2'b00;
        repeat (2) tick();

        // Reset in the cycle after an ack: read discarded, nothing issued.
        Disp_Req  = 1'b1;
        Disp_Addr = 16'h0050;
        #2; cyc_check(1'b1, 2'b00, 1'b0); expect_disp(1'b0);
        tick();
        Reset = 1'b1;
        #2; cyc_check(1'b0, 2'b00, 1'b0);
        tick();
        Reset    = 1'b0;
        Disp_Req = 1'b0;
        #2;
        check("rst_mid_disp_valid", 32'(Disp_Valid), 32'd0);
        check("rst_mid_mem_we", 32'(Mem_We), 32'd0);
        check("rst_mid_mem_addr", 32'(Mem_Addr), 32'd0);
        repeat (4) tick();

        check("op_q_drained", 32'(op_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
